// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and default constants for the system_pll bring-up sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET_HOLD,
    ST_WAIT_LOCK,
    ST_LOCK_STABLE,
    ST_RELEASE,
    ST_RUN,
    ST_FAIL
  } pll_seq_state_t;

  localparam int DEF_NUM_DOMAINS         = 6;
  localparam int DEF_RST_HOLD_CYCLES     = 50;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_RELEASE_GAP_CYCLES  = 16;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int DEF_CNT_W               = 16;

  localparam int RETRY_W = 2;

endpackage

// File: rtl/pll_lock_sequencer_bit_sync.sv
// Two-flop synchronizer for one asynchronous level input; both flops clear to 0 on reset.
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Reset/lock bring-up sequencer for system_pll: hold, wait for stable lock, staggered domain release.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_DOMAINS         = DEF_NUM_DOMAINS,
  parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int RELEASE_GAP_CYCLES  = DEF_RELEASE_GAP_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic                   refclk,
  input  logic                   rst_n,
  input  logic                   pll_locked,
  input  logic                   restart_req,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   ready,
  output logic                   lock_lost,
  output logic                   fail,
  output logic [RETRY_W-1:0]     retry_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(NUM_DOMAINS * RELEASE_GAP_CYCLES - 1);

  logic locked_s;

  pll_seq_state_t             state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0]     domain_rst_n_q, domain_rst_n_d;
  logic                       ready_q, ready_d;
  logic                       lock_lost_q, lock_lost_d;
  logic                       fail_q, fail_d;
  logic [RETRY_W-1:0]         retry_cnt_q, retry_cnt_d;
  logic [RETRY_W-1:0]         retry_inc;

  bit_sync u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  assign retry_inc = (retry_cnt_q == '1) ? retry_cnt_q : retry_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    lock_lost_d = lock_lost_q;

    case (state_q)
      ST_RESET_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_LOCK_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_cnt_d = retry_inc;
          state_d     = (int'(retry_inc) == MAX_RETRIES) ? ST_FAIL : ST_RESET_HOLD;
        end
      end
      ST_LOCK_STABLE: begin
        if (!locked_s)                 state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!locked_s) begin
          state_d     = ST_RESET_HOLD;
          lock_lost_d = 1'b1;
        end else if (cnt_q == RELEASE_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d     = ST_RESET_HOLD;
          lock_lost_d = 1'b1;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_RESET_HOLD;
      end
    endcase

    // A restart overrides whatever the state logic decided this cycle.
    if (restart_req) begin
      state_d     = ST_RESET_HOLD;
      retry_cnt_d = '0;
      lock_lost_d = 1'b0;
    end

    if (state_d == ST_RUN) retry_cnt_d = '0;

    if (restart_req || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == ST_RUN) || (state_q == ST_FAIL)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Outputs are decoded from the next state so they register in step with it.
    pll_rst_d = (state_d == ST_RESET_HOLD) || (state_d == ST_FAIL);
    ready_d   = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAIL);
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      domain_rst_n_d[i] = (state_d == ST_RUN) ||
                          ((state_d == ST_RELEASE) && (cnt_d >= CNT_W'(i * RELEASE_GAP_CYCLES)));
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q        <= ST_RESET_HOLD;
      cnt_q          <= '0;
      pll_rst_q      <= 1'b1;
      domain_rst_n_q <= '0;
      ready_q        <= 1'b0;
      lock_lost_q    <= 1'b0;
      fail_q         <= 1'b0;
      retry_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pll_rst_q      <= pll_rst_d;
      domain_rst_n_q <= domain_rst_n_d;
      ready_q        <= ready_d;
      lock_lost_q    <= lock_lost_d;
      fail_q         <= fail_d;
      retry_cnt_q    <= retry_cnt_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign domain_rst_n = domain_rst_n_q;
  assign ready        = ready_q;
  assign lock_lost    = lock_lost_q;
  assign fail         = fail_q;
  assign retry_cnt    = retry_cnt_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed bring-up scenarios plus randomized lock timing.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

  localparam int ND     = 6;
  localparam int HOLD   = 4;
  localparam int STABLE = 8;
  localparam int TMO    = 20;
  localparam int GAP    = 2;
  localparam int MAXR   = 3;
  localparam int CW     = 16;

  logic          refclk = 1'b0;
  logic          rst_n;
  logic          pll_locked;
  logic          restart_req;
  logic          pll_rst;
  logic [ND-1:0] domain_rst_n;
  logic          ready;
  logic          lock_lost;
  logic          fail;
  logic [1:0]    retry_cnt;

  int cyc;
  int errors;
  int checks;

  always #5 refclk = ~refclk;

  pll_lock_sequencer #(
    .NUM_DOMAINS         (ND),
    .RST_HOLD_CYCLES     (HOLD),
    .LOCK_STABLE_CYCLES  (STABLE),
    .LOCK_TIMEOUT_CYCLES (TMO),
    .RELEASE_GAP_CYCLES  (GAP),
    .MAX_RETRIES         (MAXR),
    .CNT_W               (CW)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .restart_req  (restart_req),
    .pll_rst      (pll_rst),
    .domain_rst_n (domain_rst_n),
    .ready        (ready),
    .lock_lost    (lock_lost),
    .fail         (fail),
    .retry_cnt    (retry_cnt)
  );

  // Cycle n is the interval just after posedge n; outputs are sampled 1 ns into it and
  // any input driven there is first seen by posedge n+1.
  task automatic tick();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic checkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checkv(tag, 32'(obs), 32'(exp));
  endtask

  task automatic check_reset_vals(input string nm);
    check1({nm, ".pll_rst"}, pll_rst, 1'b1);
    checkv({nm, ".dom"}, 32'(domain_rst_n), 32'd0);
    check1({nm, ".ready"}, ready, 1'b0);
    check1({nm, ".lock_lost"}, lock_lost, 1'b0);
    check1({nm, ".fail"}, fail, 1'b0);
    checkv({nm, ".retry"}, 32'(retry_cnt), 32'd0);
  endtask

  // Leaves the bench at cycle 0: the last reset edge has passed, rst_n is high from now on.
  task automatic do_reset();
    rst_n       = 1'b0;
    restart_req = 1'b0;
    tick();
    tick();
    cyc   = 0;
    rst_n = 1'b1;
  endtask

  function automatic logic [ND-1:0] dom_exp(input int c, input int rel);
    logic [ND-1:0] v;
    v = '0;
    for (int i = 0; i < ND; i++) v[i] = (c >= rel + i * GAP);
    return v;
  endfunction

  // Bring-up from a fresh hold starting at cycle 'base'. pll_locked rises at t_first,
  // optionally drops at t_low, and is high for good from t_final (all relative to base).
  // The synced lock is usable 2 cycles after the final rise, but never before WAIT_LOCK.
  task automatic run_lock(input string nm, input int base, input int t_first,
                          input int t_low, input int t_final);
    int entry, rel, rdy, c;
    entry = (t_final + 2 > HOLD + 1) ? t_final + 2 : HOLD + 1;
    rel   = base + entry + STABLE;
    rdy   = rel + ND * GAP;
    while (cyc <= rdy + 1) begin
      c = cyc - base;
      if (c == t_first - 1 || c == t_final - 1) pll_locked = 1'b1;
      if (c == t_low - 1) pll_locked = 1'b0;
      check1({nm, ".pll_rst"}, pll_rst, c < HOLD);
      checkv({nm, ".dom"}, 32'(domain_rst_n), 32'(dom_exp(cyc, rel)));
      check1({nm, ".ready"}, ready, cyc >= rdy);
      check1({nm, ".lock_lost"}, lock_lost, 1'b0);
      check1({nm, ".fail"}, fail, 1'b0);
      tick();
    end
  endtask

  // Called while running. Drops lock now; resets must land 3 cycles later. With
  // with_restart a restart arrives on the same edge the loss is acted on and wins.
  task automatic loss_test(input string nm, input bit with_restart);
    pll_locked = 1'b0;
    tick();
    check1({nm, ".ready_hold1"}, ready, 1'b1);
    tick();
    check1({nm, ".ready_hold2"}, ready, 1'b1);
    checkv({nm, ".dom_hold2"}, 32'(domain_rst_n), 32'((1 << ND) - 1));
    if (with_restart) restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    checkv({nm, ".dom_lost"}, 32'(domain_rst_n), 32'd0);
    check1({nm, ".ready_lost"}, ready, 1'b0);
    check1({nm, ".lock_lost"}, lock_lost, !with_restart);
    for (int k = 0; k < HOLD; k++) begin
      check1({nm, ".pll_rst_hold"}, pll_rst, 1'b1);
      tick();
    end
    check1({nm, ".pll_rst_after"}, pll_rst, 1'b0);
    check1({nm, ".lock_lost_sticky"}, lock_lost, !with_restart);
    checkv({nm, ".retry"}, 32'(retry_cnt), 32'd0);
  endtask

  initial begin
    int tf, tl, tfin, att;
    errors      = 0;
    checks      = 0;
    cyc         = 0;
    pll_locked  = 1'b0;
    restart_req = 1'b0;

    // Reset values, then clean bring-up with lock at cycle 6.
    do_reset();
    check_reset_vals("reset");
    run_lock("clean", 0, 6, -100, 6);

    // Loss of lock in RUN, then a restart clears the sticky flag.
    loss_test("loss_run", 1'b0);
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    check1("restart.lock_lost_clr", lock_lost, 1'b0);
    check1("restart.pll_rst", pll_rst, 1'b1);

    // One-cycle glitch in LOCK_STABLE.
    do_reset();
    pll_locked = 1'b0;
    run_lock("glitch", 0, 6, 10, 11);

    // Restart during RESET_HOLD restarts the hold count.
    do_reset();
    pll_locked = 1'b0;
    tick();
    tick();
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    for (int k = 0; k < HOLD; k++) begin
      check1("hold_restart.pll_rst", pll_rst, 1'b1);
      tick();
    end
    check1("hold_restart.pll_rst_end", pll_rst, 1'b0);

    // No lock at all: retries, then FAIL.
    do_reset();
    pll_locked = 1'b0;
    att = HOLD + TMO;
    while (cyc <= MAXR * att + 4) begin
      check1("nolock.pll_rst", pll_rst, (cyc >= MAXR * att) || ((cyc % att) < HOLD));
      checkv("nolock.retry", 32'(retry_cnt), (cyc / att > MAXR) ? 32'(MAXR) : 32'(cyc / att));
      check1("nolock.fail", fail, cyc >= MAXR * att);
      tick();
    end

    // Restart out of FAIL with lock already present.
    pll_locked = 1'b1;
    tick();
    tick();
    tick();
    check1("fail.still", fail, 1'b1);
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    checkv("fail_restart.retry", 32'(retry_cnt), 32'd0);
    run_lock("fail_restart", cyc, 1, -100, 1);

    // Reset in the middle of RELEASE, lock held throughout.
    do_reset();
    pll_locked = 1'b0;
    while (cyc < 20) begin
      if (cyc == 5) pll_locked = 1'b1;
      tick();
    end
    checkv("midrst.dom_partial", 32'(domain_rst_n), 32'(dom_exp(20, 16)));
    rst_n = 1'b0;
    tick();
    check_reset_vals("midrst");
    cyc   = 0;
    rst_n = 1'b1;
    run_lock("midrst_resume", 0, 1, -100, 1);

    // Randomized lock timing, optional glitch, and loss with or without a coincident restart.
    for (int n = 0; n < 6; n++) begin
      do_reset();
      pll_locked = 1'b0;
      check_reset_vals("rnd.reset");
      tf = int'($urandom_range(1, 10));
      if ($urandom_range(0, 1) == 1) begin
        tl   = tf + int'($urandom_range(1, 7));
        tfin = tl + 1;
      end else begin
        tl   = -100;
        tfin = tf;
      end
      run_lock("rnd", 0, tf, tl, tfin);
      repeat (int'($urandom_range(0, 4))) begin
        check1("rnd.run_ready", ready, 1'b1);
        tick();
      end
      loss_test("rnd_loss", 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
